rom_port_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the instruction ROM. It shares the single ROM read port between the instruction-fetch requester (`if_`) and the load/store data requester (`ls_`). It validates each request address, drives ROM enable and address, captures the ROM's registered 32-bit little-endian word, and returns it to the requester that issued it over a valid/ready handshake. It sits between the fetch stage / load-store unit and the ROM.

---
 rtl/rom_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single instruction-ROM read port between the
// fetch requester (if_) and the load/store requester (ls_). It checks each
// request address, runs one ROM read at a time and returns the 32-bit word
// (or an error) to the port that asked for it.
// Optional feature macro: ROM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration on a tie; when it is undefined, ls has fixed priority over if.
module rom_port_arbiter #(
  parameter int unsigned ROM_SIZE = 64000,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_req_addr,
  output logic        ls_resp_valid,
  input  logic        ls_resp_ready,
  output logic [31:0] ls_resp_data,
  output logic        ls_resp_err,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

  localparam logic [32:0] RomSize33 = 33'(ROM_SIZE);
  localparam logic [32:0] RomBase33 = {1'b0, ROM_BASE};

  state_e      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic        rom_en_q, rom_en_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        if_resp_valid_q, if_resp_valid_d;
  logic        ls_resp_valid_q, ls_resp_valid_d;

  logic        grant_ls;
  logic        grant_if;
  logic        accept_en;
  logic        req_fire;
  logic [31:0] sel_addr;
  logic [32:0] addr33;
  logic [32:0] off33;
  logic [32:0] last33;
  logic        addr_ok;
  logic        owner_resp_ready;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic        last_ls_q, last_ls_d;

  // On a tie the port that did not win last time gets the grant.
  assign grant_ls = ls_req_valid & (~if_req_valid | ~last_ls_q);
`else
  // Load/store always beats fetch when both ask at once.
  assign grant_ls = ls_req_valid;
`endif

  assign grant_if     = if_req_valid & ~grant_ls;
  assign accept_en    = rst_n & (state_q == IDLE);
  assign ls_req_ready = accept_en & grant_ls;
  assign if_req_ready = accept_en & grant_if;
  assign req_fire     = ls_req_ready | if_req_ready;

  // Range check is done in 33 bits so base subtraction and the +3 cannot wrap.
  assign sel_addr = grant_ls ? ls_req_addr : if_req_addr;
  assign addr33   = {1'b0, sel_addr};
  assign off33    = addr33 - RomBase33;
  assign last33   = off33 + 33'd3;
  assign addr_ok  = (sel_addr[1:0] == 2'b00) && (addr33 >= RomBase33) &&
                    (last33 < RomSize33);

  assign owner_resp_ready = owner_ls_q ? ls_resp_ready : if_resp_ready;

  assign rom_en        = rom_en_q;
  assign rom_addr      = rom_addr_q;
  assign if_resp_valid = if_resp_valid_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign if_resp_data  = resp_data_q;
  assign ls_resp_data  = resp_data_q;
  assign if_resp_err   = resp_err_q;
  assign ls_resp_err   = resp_err_q;

  // Next-state and registered-output logic for the single outstanding transaction.
  always_comb begin
    state_d         = state_q;
    owner_ls_d      = owner_ls_q;
    rom_en_d        = rom_en_q;
    rom_addr_d      = rom_addr_q;
    resp_data_d     = resp_data_q;
    resp_err_d      = resp_err_q;
    if_resp_valid_d = if_resp_valid_q;
    ls_resp_valid_d = ls_resp_valid_q;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    last_ls_d       = last_ls_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          owner_ls_d = grant_ls;
`ifdef ROM_ARB_ROUND_ROBIN_EN
          last_ls_d  = grant_ls;
`endif
          if (addr_ok) begin
            state_d    = ACCESS;
            rom_en_d   = 1'b1;
            rom_addr_d = off33[31:0];
          end else begin
            state_d         = RESP;
            resp_data_d     = 32'h0;
            resp_err_d      = 1'b1;
            if_resp_valid_d = ~grant_ls;
            ls_resp_valid_d = grant_ls;
          end
        end
      end
      ACCESS: begin
        rom_en_d = 1'b0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        resp_data_d     = rom_data;
        resp_err_d      = 1'b0;
        if_resp_valid_d = ~owner_ls_q;
        ls_resp_valid_d = owner_ls_q;
        state_d         = RESP;
      end
      RESP: begin
        if (owner_resp_ready) begin
          if_resp_valid_d = 1'b0;
          ls_resp_valid_d = 1'b0;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_ls_q      <= 1'b0;
      rom_en_q        <= 1'b0;
      rom_addr_q      <= 32'h0;
      resp_data_q     <= 32'h0;
      resp_err_q      <= 1'b0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_ls_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      owner_ls_q      <= owner_ls_d;
      rom_en_q        <= rom_en_d;
      rom_addr_q      <= rom_addr_d;
      resp_data_q     <= resp_data_d;
      resp_err_q      <= resp_err_d;
      if_resp_valid_q <= if_resp_valid_d;
      ls_resp_valid_q <= ls_resp_valid_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_ls_q       <= last_ls_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: a transaction-level reference
// model checks every cycle, directed sequences pin known values, and a
// randomized phase exercises arbitration, errors, backpressure and resets.
module tb_rom_port_arbiter;

  localparam int unsigned ROM_SIZE = 64000;
  localparam logic [31:0] ROM_BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, ls_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0, ls_req_addr = '0;
  logic        if_resp_ready = 1'b1, ls_resp_ready = 1'b1;
  logic        if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid;
  logic [31:0] if_resp_data, ls_resp_data;
  logic        if_resp_err, ls_resp_err;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;

  // Second instance with a nonzero base and a small ROM.
  logic        b_if_req_valid = 1'b0;
  logic [31:0] b_if_req_addr = '0;
  logic        b_if_req_ready, b_if_resp_valid, b_if_resp_err;
  logic [31:0] b_if_resp_data;
  logic        b_ls_req_ready, b_ls_resp_valid, b_ls_resp_err;
  logic [31:0] b_ls_resp_data;
  logic        b_rom_en;
  logic [31:0] b_rom_addr;
  logic [31:0] b_rom_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  rom_port_arbiter #(.ROM_SIZE(ROM_SIZE), .ROM_BASE(ROM_BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
    .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  rom_port_arbiter #(.ROM_SIZE(256), .ROM_BASE(32'h1000)) dutB (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_addr(b_if_req_addr),
    .if_resp_valid(b_if_resp_valid), .if_resp_ready(1'b1),
    .if_resp_data(b_if_resp_data), .if_resp_err(b_if_resp_err),
    .ls_req_valid(1'b0), .ls_req_ready(b_ls_req_ready), .ls_req_addr(32'h0),
    .ls_resp_valid(b_ls_resp_valid), .ls_resp_ready(1'b1),
    .ls_resp_data(b_ls_resp_data), .ls_resp_err(b_ls_resp_err),
    .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_data(b_rom_data)
  );

  always #5 clk = ~clk;

  // ROM content: byte k holds k[7:0] ^ k[15:8]; words are little-endian.
  function automatic logic [7:0] romByte(input logic [31:0] k);
    return k[7:0] ^ k[15:8];
  endfunction

  function automatic logic [31:0] romWord(input logic [31:0] off);
    return {romByte(off + 32'd3), romByte(off + 32'd2), romByte(off + 32'd1), romByte(off)};
  endfunction

  // Registered ROMs: data appears the cycle after enable.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rom_en) rom_data <= romWord(rom_addr);
    if (b_rom_en) b_rom_data <= romWord(b_rom_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  bit          mBusy = 0, mOwnerLs = 0, mOk = 0, mAfterReset = 0, mLastLs = 0;
  logic [31:0] mOff = '0, mData = '0;
  int          mAcc = 0, mResp = 0;

  always @(negedge clk) begin
    bit          wLs, eEn, eValid;
    logic [31:0] a;
    longint      la;
    if (!rst_n) begin
      checkOutput("if_req_ready in reset", if_req_ready, 0);
      checkOutput("ls_req_ready in reset", ls_req_ready, 0);
      mBusy = 0; mAfterReset = 1; mLastLs = 0;
    end else begin
      if (mAfterReset) begin
        checkOutput("rom_en after reset", rom_en, 0);
        checkOutput("rom_addr after reset", rom_addr, 0);
        checkOutput("if_resp_valid after reset", if_resp_valid, 0);
        checkOutput("ls_resp_valid after reset", ls_resp_valid, 0);
        checkOutput("if_resp_data after reset", if_resp_data, 0);
        checkOutput("ls_resp_data after reset", ls_resp_data, 0);
        checkOutput("if_resp_err after reset", if_resp_err, 0);
        checkOutput("ls_resp_err after reset", ls_resp_err, 0);
        mAfterReset = 0;
      end
`ifdef ROM_ARB_ROUND_ROBIN_EN
      wLs = ls_req_valid && (!if_req_valid || !mLastLs);
`else
      wLs = ls_req_valid;
`endif
      checkOutput("if_req_ready", if_req_ready, !mBusy && if_req_valid && !wLs);
      checkOutput("ls_req_ready", ls_req_ready, !mBusy && wLs);
      eEn = mBusy && mOk && (cyc == mAcc + 1);
      checkOutput("rom_en", rom_en, eEn);
      if (eEn) checkOutput("rom_addr", rom_addr, mOff);
      eValid = mBusy && (cyc >= mResp);
      checkOutput("if_resp_valid", if_resp_valid, eValid && !mOwnerLs);
      checkOutput("ls_resp_valid", ls_resp_valid, eValid && mOwnerLs);
      if (eValid) begin
        checkOutput("resp_data", mOwnerLs ? ls_resp_data : if_resp_data, mData);
        checkOutput("resp_err", mOwnerLs ? ls_resp_err : if_resp_err, !mOk);
      end
      if (!mBusy) begin
        if (if_req_valid || ls_req_valid) begin
          a = wLs ? ls_req_addr : if_req_addr;
          la = longint'(a);
          mOk = (la % 4 == 0) && (la >= longint'(ROM_BASE)) &&
                (la - longint'(ROM_BASE) + 3 < longint'(ROM_SIZE));
          mOff = a - ROM_BASE;
          mData = mOk ? romWord(mOff) : 32'h0;
          mAcc = cyc;
          mResp = cyc + (mOk ? 3 : 1);
          mOwnerLs = wLs;
          mLastLs = wLs;
          mBusy = 1;
        end
      end else if (eValid && (mOwnerLs ? ls_resp_ready : if_resp_ready)) begin
        mBusy = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle;
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    repeat (n) nextCycle();
    rst_n = 1'b1;
  endtask

  // One request on the main instance with hand-computed expectations.
  task automatic directedRequest(input bit useLs, input logic [31:0] addr,
                                 input bit expErr, input logic [31:0] expData);
    if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
    if (useLs) begin ls_req_valid = 1'b1; ls_req_addr = addr; end
    else begin if_req_valid = 1'b1; if_req_addr = addr; end
    midCycle();
    checkOutput("directed req_ready", useLs ? ls_req_ready : if_req_ready, 1);
    nextCycle();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    if (!expErr) begin
      midCycle();
      checkOutput("directed rom_en high", rom_en, 1);
      checkOutput("directed rom_addr", rom_addr, addr);
      nextCycle();
      midCycle();
      checkOutput("directed rom_en capture", rom_en, 0);
      nextCycle();
    end
    midCycle();
    checkOutput("directed rom_en at resp", rom_en, 0);
    checkOutput("directed own resp_valid", useLs ? ls_resp_valid : if_resp_valid, 1);
    checkOutput("directed other resp_valid", useLs ? if_resp_valid : ls_resp_valid, 0);
    checkOutput("directed resp_data", useLs ? ls_resp_data : if_resp_data, expData);
    checkOutput("directed resp_err", useLs ? ls_resp_err : if_resp_err, expErr);
    nextCycle();
  endtask

  // One request on the nonzero-base instance.
  task automatic bRequest(input logic [31:0] addr, input bit expErr,
                          input logic [31:0] expOff, input logic [31:0] expData);
    b_if_req_valid = 1'b1; b_if_req_addr = addr;
    midCycle();
    checkOutput("base req_ready", b_if_req_ready, 1);
    nextCycle();
    b_if_req_valid = 1'b0;
    if (!expErr) begin
      midCycle();
      checkOutput("base rom_en", b_rom_en, 1);
      checkOutput("base rom_addr", b_rom_addr, expOff);
      nextCycle();
      nextCycle();
    end
    midCycle();
    checkOutput("base rom_en at resp", b_rom_en, 0);
    checkOutput("base resp_valid", b_if_resp_valid, 1);
    checkOutput("base resp_err", b_if_resp_err, expErr);
    checkOutput("base resp_data", b_if_resp_data, expData);
    nextCycle();
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return 32'($urandom_range(0, 15999)) * 32'd4;
      5:             return 32'($urandom_range(0, 63999)) | 32'd1;
      6:             return 32'($urandom_range(63988, 64008));
      7:             return $urandom;
      default:       return 32'($urandom_range(0, 31)) * 32'd4;
    endcase
  endfunction

  // Randomized requesters that honour the hold-while-not-ready rule.
  task automatic applyStimulus(input int nCycles);
    bit ifPend = 0, lsPend = 0;
    for (int i = 0; i < nCycles; i++) begin
      if (!ifPend) begin
        if_req_valid = ($urandom_range(0, 2) != 0);
        if_req_addr = randAddr();
      end
      if (!lsPend) begin
        ls_req_valid = ($urandom_range(0, 2) != 0);
        ls_req_addr = randAddr();
      end
      if_resp_ready = ($urandom_range(0, 3) != 0);
      ls_resp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 79) != 0);
      midCycle();
      ifPend = if_req_valid && !if_req_ready;
      lsPend = ls_req_valid && !ls_req_ready;
      nextCycle();
    end
    rst_n = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0;
    if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
    repeat (6) nextCycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit grants[$];
    int ifHigh;
    bit seen;
    $display("[TB] start");
    nextCycle();
    doReset(3);

    // Fetch of word 0 and the address boundary cases.
    directedRequest(0, 32'h0, 0, 32'h0302_0100);
    directedRequest(1, 32'h2, 1, 32'h0);
    directedRequest(0, 32'd63998, 1, 32'h0);
    directedRequest(0, 32'd63996, 0, 32'h0607_0405);
    directedRequest(1, 32'd64000, 1, 32'h0);

    // Contention straight out of reset.
    doReset(2);
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    ls_req_valid = 1'b1; ls_req_addr = 32'h200;
    ifHigh = 0;
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      midCycle();
      if (if_req_ready) begin grants.push_back(0); ifHigh++; end
      if (ls_req_ready) grants.push_back(1);
      nextCycle();
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (5) nextCycle();
    checkOutput("contention grant count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
      checkOutput($sformatf("rr grant %0d is ls", i), grants[i], (i % 2 == 0) ? 1 : 0);
`else
      checkOutput($sformatf("fixed grant %0d is ls", i), grants[i], 1);
`endif
    end
`ifndef ROM_ARB_ROUND_ROBIN_EN
    checkOutput("fixed if_req_ready never high", ifHigh, 0);
`endif

    // Backpressure on the fetch response while ls keeps asking.
    if_resp_ready = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    midCycle();
    checkOutput("bp req_ready", if_req_ready, 1);
    nextCycle();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b1; ls_req_addr = 32'h40;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      midCycle();
      if (if_resp_valid) seen = 1;
      else nextCycle();
    end
    checkOutput("bp response arrived", seen, 1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp valid held", if_resp_valid, 1);
      checkOutput("bp data held", if_resp_data, 32'h0B0A_0908);
      checkOutput("bp err held", if_resp_err, 0);
      checkOutput("bp ls_req_ready low", ls_req_ready, 0);
      checkOutput("bp if_req_ready low", if_req_ready, 0);
      nextCycle();
      if (k == 4) if_resp_ready = 1'b1;
      midCycle();
    end
    checkOutput("bp valid at ready", if_resp_valid, 1);
    nextCycle();
    midCycle();
    checkOutput("bp idle next cycle", ls_req_ready, 1);
    checkOutput("bp valid cleared", if_resp_valid, 0);
    nextCycle();
    ls_req_valid = 1'b0;
    repeat (5) nextCycle();

    // Reset while the ROM word is being captured.
    if_req_valid = 1'b1; if_req_addr = 32'hC;
    midCycle();
    nextCycle();
    if_req_valid = 1'b0;
    nextCycle();
    rst_n = 1'b0;
    midCycle();
    nextCycle();
    rst_n = 1'b1;
    midCycle();
    checkOutput("capture-reset rom_en", rom_en, 0);
    checkOutput("capture-reset rom_addr", rom_addr, 0);
    checkOutput("capture-reset if_resp_valid", if_resp_valid, 0);
    checkOutput("capture-reset if_resp_data", if_resp_data, 0);
    checkOutput("capture-reset if_resp_err", if_resp_err, 0);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      midCycle();
      checkOutput("no resp after reset", if_resp_valid, 0);
    end
    nextCycle();
    directedRequest(0, 32'h10, 0, 32'h1312_1110);

    // Nonzero base instance.
    bRequest(32'h1004, 0, 32'h4, 32'h0706_0504);
    bRequest(32'h0FFC, 1, 32'h0, 32'h0);
    bRequest(32'h10FC, 0, 32'hFC, romWord(32'hFC));
    bRequest(32'h1100, 1, 32'h0, 32'h0);

    // Randomized traffic against the model.
    applyStimulus(1500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
